// File: rtl/decoder_func_gen.sv
// rtl/decoder_func_gen.sv - serially configured N-to-2^N decoder driving M programmable sum-of-minterm functions
//
// Purpose:
//   Holds M minterm masks of 2^N bits each, loaded serially after cfg_start.
//   Once loaded, each accepted select word is one-hot decoded (stage 1) and
//   ANDed/ORed against every mask (stage 2), giving out_f two cycles later.
//
// Optional feature:
//   DEC_HITCNT_EN - adds hit_cnt, one saturating 16-bit counter per function.
//
// Ports:
//   clk           - sole clock, rising edge
//   rst           - asynchronous active-high reset
//   cfg_start     - pulse: enter LOAD, clear masks/counters, flush pipeline
//   cfg_bit_valid - qualifies cfg_bit while in LOAD
//   cfg_bit       - serial mask data; bit k -> mask[k / 2^N][k mod 2^N]
//   busy          - high while unconfigured or loading
//   en            - decoder enable, sampled with in_valid
//   in_valid      - qualifies in_data (accepted only in READY)
//   in_data       - N-bit select word
//   out_valid     - result valid, 2 cycles after an accepted input
//   out_f         - M function results, held while out_valid is low
//   hit_cnt       - (DEC_HITCNT_EN only) 16 bits per function, function m at [16m+15:16m]

module decoder_func_gen #(
  parameter int N = 4,
  parameter int M = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_start,
  input  logic             cfg_bit_valid,
  input  logic             cfg_bit,
  output logic             busy,
  input  logic             en,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  output logic [M-1:0]     out_f
`ifdef DEC_HITCNT_EN
  ,
  output logic [16*M-1:0]  hit_cnt
`endif
);

  localparam int NM    = 1 << N;          // minterms per function
  localparam int TOTAL = M * NM;          // serial bits per full load
  localparam int CW    = $clog2(TOTAL + 1);

  localparam logic [1:0] ST_UNCFG = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [CW-1:0]     bit_cnt_q,   bit_cnt_d;
  logic [TOTAL-1:0]  mask_q,      mask_d;
  logic              s1_valid_q,  s1_valid_d;
  logic [NM-1:0]     s1_dec_q,    s1_dec_d;
  logic              out_valid_q, out_valid_d;
  logic [M-1:0]      out_f_q,     out_f_d;

  logic [NM-1:0]     dec_w;
  logic [M-1:0]      fn_w;
  logic              accept_in;
  logic              last_bit;

  // In-range select word is exactly N bits wide, so the index always hits.
  always_comb begin
    dec_w          = '0;
    dec_w[in_data] = en;
  end

  always_comb begin
    fn_w = '0;
    for (int m = 0; m < M; m++) begin
      fn_w[m] = |(s1_dec_q & mask_q[m*NM +: NM]);
    end
  end

  // cfg_start steals the cycle: any in_valid alongside it is dropped.
  assign accept_in = in_valid && (state_q == ST_READY) && !cfg_start;
  assign last_bit  = (bit_cnt_q == CW'(TOTAL - 1));

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    mask_d      = mask_q;
    s1_valid_d  = accept_in;
    s1_dec_d    = s1_dec_q;
    out_valid_d = s1_valid_q;
    out_f_d     = out_f_q;

    if (accept_in) begin
      s1_dec_d = dec_w;
    end
    if (s1_valid_q) begin
      out_f_d = fn_w;
    end

    if (cfg_start) begin
      state_d     = ST_LOAD;
      bit_cnt_d   = '0;
      mask_d      = '0;
      s1_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (state_q == ST_LOAD && cfg_bit_valid) begin
      // Shift in from the top: after exactly TOTAL bits the first bit sits
      // at index 0, so serial bit k ends up at mask index k.
      mask_d = {cfg_bit, mask_q[TOTAL-1:1]};
      if (last_bit) begin
        state_d   = ST_READY;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNCFG;
      bit_cnt_q   <= '0;
      mask_q      <= '0;
      s1_valid_q  <= 1'b0;
      s1_dec_q    <= '0;
      out_valid_q <= 1'b0;
      out_f_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      mask_q      <= mask_d;
      s1_valid_q  <= s1_valid_d;
      s1_dec_q    <= s1_dec_d;
      out_valid_q <= out_valid_d;
      out_f_q     <= out_f_d;
    end
  end

  assign busy      = (state_q != ST_READY);
  assign out_valid = out_valid_q;
  assign out_f     = out_f_q;

`ifdef DEC_HITCNT_EN
  logic [16*M-1:0] hit_q, hit_d;

  always_comb begin
    hit_d = hit_q;
    for (int m = 0; m < M; m++) begin
      if (cfg_start) begin
        hit_d[16*m +: 16] = 16'h0000;
      end else if (out_valid_q && out_f_q[m] && (hit_q[16*m +: 16] != 16'hFFFF)) begin
        hit_d[16*m +: 16] = hit_q[16*m +: 16] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_cnt = hit_q;
`endif

endmodule

// File: doc/decoder_func_gen.md
DECODER_FUNC_GEN -- requirements
Module: decoder_func_gen

Interface
REQ-001 SHALL have parameter N, default 4, number of select inputs (legal range 2..6).
REQ-002 SHALL have parameter M, default 3, number of output functions (legal range 1..8).
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port cfg_start, input, 1, pulse that begins loading minterm masks.
REQ-006 SHALL have port cfg_bit_valid, input, 1, qualifies cfg_bit.
REQ-007 SHALL have port cfg_bit, input, 1, serial mask data.
REQ-008 SHALL have port busy, output, 1, high in UNCFG and LOAD.
REQ-009 SHALL have port en, input, 1, decoder enable, sampled with in_valid.
REQ-010 SHALL have port in_valid, input, 1, qualifies in_data.
REQ-011 SHALL have port in_data, input, N, select word (bit N-1 is MSB).
REQ-012 SHALL have port out_valid, output, 1, result valid.
REQ-013 SHALL have port out_f, output, M, function results (bit m is function m).
REQ-014 SHALL have port hit_cnt, output, 16*M, per-function hit counters (bits 16m+15:16m are function m); present only under DEC_HITCNT_EN.

Function
REQ-015 SHALL hold M masks of 2^N bits each; out_f[m] is 1 iff mask[m][in_data] is 1 and en was 1.
REQ-016 SHALL implement FSM states UNCFG, LOAD and READY.
REQ-017 SHALL transition UNCFG->LOAD and READY->LOAD on cfg_start.
REQ-018 SHALL transition LOAD->READY in the cycle after the M*2^N-th accepted cfg_bit.
REQ-019 SHALL, in LOAD, shift one cfg_bit per cycle in which cfg_bit_valid=1, and SHALL accept no bit while cfg_bit_valid=0, with no timeout.
REQ-020 SHALL write serial bit k into mask[k / 2^N][k mod 2^N], so the first bit loaded is function 0, minterm 0.
REQ-021 SHALL clear all masks and the bit counter on entry to LOAD.
REQ-022 SHALL restart loading from bit 0 on a cfg_start received during LOAD.
REQ-023 SHALL ignore cfg_bit_valid outside LOAD.
REQ-024 SHALL accept inputs only in READY; in_valid in UNCFG or LOAD is dropped and produces no out_valid.
REQ-025 SHALL, in stage 1, register in_valid and the one-hot 2^N-bit decode of in_data; the decode is all-zero when en=0.
REQ-026 SHALL, in stage 2, register out_f[m] = OR over (stage-1 decode AND mask[m]), together with out_valid.
REQ-027 SHALL have a latency of 2 cycles: out_valid is high exactly 2 cycles after each accepted in_valid; throughput is 1 per cycle with no stalls.
REQ-028 SHALL, when en=0, still pulse out_valid with out_f all zero.
REQ-029 SHALL hold out_f at its last value while out_valid=0.
REQ-030 SHALL clear both pipeline valid bits on cfg_start, discarding results in flight.
REQ-031 SHALL ignore in_valid in the cycle cfg_start is high.

Reset
REQ-032 SHALL, on rst, asynchronously force FSM=UNCFG, masks=0, bit counter=0, pipeline valids=0, out_valid=0, out_f=0, hit_cnt=0, busy=1.
REQ-033 SHALL, on rst mid-LOAD, discard all partially loaded mask bits.
REQ-034 SHALL release rst into UNCFG, and SHALL NOT produce out_valid until a full load completes.

Configuration
REQ-035 SHALL, when DEC_HITCNT_EN is defined, provide hit_cnt with one 16-bit counter per function that increments when out_valid=1 and out_f[m]=1.
REQ-036 SHALL saturate each hit counter at 16'hFFFF.
REQ-037 SHALL clear the hit counters on rst and on cfg_start.
REQ-038 SHALL, when DEC_HITCNT_EN is not defined, have no hit_cnt port and no counter logic, with all other behaviour identical.

Verification
REQ-039 SHALL cover: N=4, M=3; load masks f=16'h4CC8, g=16'h440C, h=16'hC08C; then sweep in_data 0..15 back-to-back with en=1 -> out_f matches the masks (e.g. in_data 4'b0111 gives f=1, g=0, h=1), with out_valid 2 cycles after each input.
REQ-040 SHALL cover: in_data=4'd3 with en=0 -> out_valid=1 and out_f=3'b000 after 2 cycles.
REQ-041 SHALL cover: in_valid asserted during LOAD and in UNCFG after reset -> no out_valid.
REQ-042 SHALL cover: rst asserted after 20 of 48 load bits -> busy=1, then a reload with g=16'h0004 and inputs 2 and 3 -> g is 1 and 0 respectively.
REQ-043 SHALL cover: cfg_start while 2 results are in flight -> neither result appears, and busy=1 on the next cycle.
REQ-044 SHALL cover, with DEC_HITCNT_EN: 70000 consecutive inputs with in_data=4'd14 -> hit_cnt for all three functions saturates at 16'hFFFF.
